// File: rtl/cpu_pkg.sv
// Shared types for the 12-bit microprocessor control path.
// Opcodes, sequencer states, multi-cycle op codes and field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_SUB   = 3'd2,
        OP_ADD   = 3'd3,
        OP_ASC   = 3'd4,
        OP_DESC  = 3'd5,
        OP_DISP  = 3'd6,
        OP_HALT  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WAIT,
        NEXT,
        HALT
    } state_e;

    localparam logic [1:0] MC_ASC  = 2'b00;
    localparam logic [1:0] MC_DESC = 2'b01;
    localparam logic [1:0] MC_DISP = 2'b10;

    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 9;
    localparam int DST_MSB  = 8;
    localparam int DST_LSB  = 6;
    localparam int SRCA_MSB = 5;
    localparam int SRCA_LSB = 3;
    localparam int SRCB_MSB = 2;
    localparam int SRCB_LSB = 0;
    localparam int MREG_MSB = 6;
    localparam int MREG_LSB = 4;
    localparam int DM_MSB   = 3;
    localparam int DM_LSB   = 0;
    localparam int ARG_MSB  = 8;
    localparam int ARG_LSB  = 0;

    function automatic logic is_multi(input opcode_e op);
        return (op == OP_ASC) || (op == OP_DESC) || (op == OP_DISP);
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Datapath strobe decoder: maps the latched instruction and state
// to register file, ALU, data memory and multi-cycle unit controls.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 12
) (
    input  state_e             state,
    input  logic [INSTR_W-1:0] ir,
    output logic               rf_we,
    output logic [2:0]         rf_wa,
    output logic [2:0]         rf_ra0,
    output logic [2:0]         rf_ra1,
    output logic               alu_sub,
    output logic               wb_sel,
    output logic               dm_we,
    output logic [3:0]         dm_addr,
    output logic               mc_start,
    output logic [1:0]         mc_op,
    output logic [8:0]         mc_arg
);

    opcode_e op;
    assign op = opcode_e'(ir[OP_MSB:OP_LSB]);

    // Strobes fire only in EXEC; mc_op/mc_arg held through the wait.
    always_comb begin
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_ra0   = '0;
        rf_ra1   = '0;
        alu_sub  = 1'b0;
        wb_sel   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        mc_start = 1'b0;
        mc_op    = '0;
        mc_arg   = '0;
        if (state == EXEC) begin
            unique case (op)
                OP_LOAD: begin
                    rf_we   = 1'b1;
                    wb_sel  = 1'b1;
                    rf_wa   = ir[MREG_MSB:MREG_LSB];
                    dm_addr = ir[DM_MSB:DM_LSB];
                end
                OP_STORE: begin
                    dm_we   = 1'b1;
                    rf_ra0  = ir[MREG_MSB:MREG_LSB];
                    dm_addr = ir[DM_MSB:DM_LSB];
                end
                OP_SUB, OP_ADD: begin
                    rf_we   = 1'b1;
                    alu_sub = (op == OP_SUB);
                    rf_wa   = ir[DST_MSB:DST_LSB];
                    rf_ra0  = ir[SRCA_MSB:SRCA_LSB];
                    rf_ra1  = ir[SRCB_MSB:SRCB_LSB];
                end
                OP_ASC, OP_DESC, OP_DISP: begin
                    mc_start = 1'b1;
                end
                OP_HALT: begin
                end
            endcase
        end
        if ((state == EXEC || state == WAIT) && is_multi(op)) begin
            mc_arg = ir[ARG_MSB:ARG_LSB];
            unique case (op)
                OP_ASC:  mc_op = MC_ASC;
                OP_DESC: mc_op = MC_DESC;
                default: mc_op = MC_DISP;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM with single-step, free-run and
// a watchdog on multi-cycle operations.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 12,
    parameter int PC_W    = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               run_mode,
    input  logic               prog_mode,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mc_done,
    output logic [PC_W-1:0]    imem_addr,
    output logic               rf_we,
    output logic [2:0]         rf_wa,
    output logic [2:0]         rf_ra0,
    output logic [2:0]         rf_ra1,
    output logic               alu_sub,
    output logic               wb_sel,
    output logic               dm_we,
    output logic [3:0]         dm_addr,
    output logic               mc_start,
    output logic [1:0]         mc_op,
    output logic [8:0]         mc_arg,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [PC_W-1:0]    pc
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_e             state, state_n;
    logic [PC_W-1:0]    pc_n;
    logic [INSTR_W-1:0] ir, ir_n;
    logic [WD_W-1:0]    wdog, wdog_n, wd_inc;
    logic               err_n;
    opcode_e            op;

    assign op        = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign wd_inc    = wdog + 1'b1;
    assign imem_addr = pc;
    assign busy      = (state != IDLE) && (state != HALT);
    assign halted    = (state == HALT);

    // State, pc, ir, watchdog and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            wdog  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            wdog  <= wdog_n;
            err   <= err_n;
        end
    end

    // Next-state logic; mc_done wins over a same-cycle timeout.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        wdog_n  = wdog;
        err_n   = err;
        unique case (state)
            IDLE: begin
                if (go && !prog_mode) state_n = FETCH;
            end
            FETCH: begin
                state_n = DECODE;
            end
            DECODE: begin
                ir_n    = instr_in;
                state_n = EXEC;
            end
            EXEC: begin
                if (op == OP_HALT) begin
                    state_n = HALT;
                end else if (is_multi(op)) begin
                    wdog_n  = '0;
                    state_n = WAIT;
                end else begin
                    pc_n    = pc + 1'b1;
                    state_n = NEXT;
                end
            end
            WAIT: begin
                if (mc_done) begin
                    pc_n    = pc + 1'b1;
                    state_n = NEXT;
                end else if (wd_inc == WD_MAX) begin
                    err_n   = 1'b1;
                    state_n = HALT;
                end else begin
                    wdog_n  = wd_inc;
                end
            end
            NEXT: begin
                state_n = (run_mode && !prog_mode) ? FETCH : IDLE;
            end
            HALT: begin
                if (go) begin
                    pc_n    = '0;
                    err_n   = 1'b0;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    cpu_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .state    (state),
        .ir       (ir),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_ra0   (rf_ra0),
        .rf_ra1   (rf_ra1),
        .alu_sub  (alu_sub),
        .wb_sel   (wb_sel),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .mc_start (mc_start),
        .mc_op    (mc_op),
        .mc_arg   (mc_arg)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed program scenarios
// followed by randomized traffic against a behavioural model.
module tb_cpu_sequencer;

    localparam int TO = 15;

    localparam int P_IDLE   = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DECODE = 2;
    localparam int P_EXEC   = 3;
    localparam int P_WAIT   = 4;
    localparam int P_NEXT   = 5;
    localparam int P_HALT   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        run_mode;
    logic        prog_mode;
    logic [11:0] instr_in = '0;
    logic        mc_done;
    logic [2:0]  imem_addr;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [2:0]  rf_ra0;
    logic [2:0]  rf_ra1;
    logic        alu_sub;
    logic        wb_sel;
    logic        dm_we;
    logic [3:0]  dm_addr;
    logic        mc_start;
    logic [1:0]  mc_op;
    logic [8:0]  mc_arg;
    logic        busy;
    logic        halted;
    logic        err;
    logic [2:0]  pc;

    logic [11:0] mem [8];

    int checks = 0;
    int errors = 0;

    int resp_delay = 0;
    int cnt = 0;

    int          m_ph   = P_IDLE;
    int          m_pc   = 0;
    int          m_wait = 0;
    logic [11:0] m_ir   = '0;
    logic        m_err  = 1'b0;

    always #5 clk = ~clk;

    // Registered instruction memory read port.
    always @(posedge clk) instr_in <= mem[imem_addr];

    cpu_sequencer #(
        .INSTR_W (12),
        .PC_W    (3),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .run_mode  (run_mode),
        .prog_mode (prog_mode),
        .instr_in  (instr_in),
        .mc_done   (mc_done),
        .imem_addr (imem_addr),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_ra0    (rf_ra0),
        .rf_ra1    (rf_ra1),
        .alu_sub   (alu_sub),
        .wb_sel    (wb_sel),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .mc_start  (mc_start),
        .mc_op     (mc_op),
        .mc_arg    (mc_arg),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .pc        (pc)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one step per clock, instruction read straight from mem.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   <= P_IDLE;
            m_pc   <= 0;
            m_ir   <= '0;
            m_wait <= 0;
            m_err  <= 1'b0;
        end else begin
            case (m_ph)
                P_IDLE:   if (go && !prog_mode) m_ph <= P_FETCH;
                P_FETCH:  m_ph <= P_DECODE;
                P_DECODE: begin
                    m_ir <= mem[m_pc];
                    m_ph <= P_EXEC;
                end
                P_EXEC: begin
                    if (m_ir[11:9] == 3'd7) begin
                        m_ph <= P_HALT;
                    end else if (m_ir[11:9] >= 3'd4) begin
                        m_wait <= 0;
                        m_ph   <= P_WAIT;
                    end else begin
                        m_pc <= (m_pc + 1) % 8;
                        m_ph <= P_NEXT;
                    end
                end
                P_WAIT: begin
                    m_wait <= m_wait + 1;
                    if (mc_done) begin
                        m_pc <= (m_pc + 1) % 8;
                        m_ph <= P_NEXT;
                    end else if (m_wait + 1 == TO) begin
                        m_err <= 1'b1;
                        m_ph  <= P_HALT;
                    end
                end
                P_NEXT:   m_ph <= (run_mode && !prog_mode) ? P_FETCH : P_IDLE;
                P_HALT: begin
                    if (go) begin
                        m_pc  <= 0;
                        m_err <= 1'b0;
                        m_ph  <= P_FETCH;
                    end
                end
                default:  m_ph <= P_IDLE;
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        int          op;
        logic        e_we, e_sub, e_wb, e_dwe, e_mcs;
        logic [2:0]  e_wa, e_ra0, e_ra1;
        logic [3:0]  e_dm;
        logic [1:0]  e_mop;
        logic [8:0]  e_arg;
        forever begin
            @(negedge clk);
            op    = int'(m_ir[11:9]);
            e_we  = 0; e_sub = 0; e_wb = 0; e_dwe = 0; e_mcs = 0;
            e_wa  = 0; e_ra0 = 0; e_ra1 = 0; e_dm = 0;
            e_mop = 0; e_arg = 0;
            if (m_ph == P_EXEC) begin
                if (op == 0) begin
                    e_we = 1; e_wb = 1;
                    e_wa = m_ir[6:4]; e_dm = m_ir[3:0];
                end else if (op == 1) begin
                    e_dwe = 1;
                    e_ra0 = m_ir[6:4]; e_dm = m_ir[3:0];
                end else if (op == 2 || op == 3) begin
                    e_we  = 1; e_sub = (op == 2);
                    e_wa  = m_ir[8:6];
                    e_ra0 = m_ir[5:3];
                    e_ra1 = m_ir[2:0];
                end else if (op != 7) begin
                    e_mcs = 1;
                end
            end
            if ((m_ph == P_EXEC || m_ph == P_WAIT) && op >= 4 && op <= 6) begin
                e_mop = 2'(op - 4);
                e_arg = m_ir[8:0];
            end
            check("rf_we", rf_we, e_we);
            check("rf_wa", rf_wa, e_wa);
            check("rf_ra0", rf_ra0, e_ra0);
            check("rf_ra1", rf_ra1, e_ra1);
            check("alu_sub", alu_sub, e_sub);
            check("wb_sel", wb_sel, e_wb);
            check("dm_we", dm_we, e_dwe);
            check("dm_addr", dm_addr, e_dm);
            check("mc_start", mc_start, e_mcs);
            check("mc_op", mc_op, e_mop);
            check("mc_arg", mc_arg, e_arg);
            check("busy", busy, (m_ph != P_IDLE && m_ph != P_HALT));
            check("halted", halted, (m_ph == P_HALT));
            check("err", err, m_err);
            check("pc", pc, m_pc);
            check("imem_addr", imem_addr, m_pc);
        end
    end

    // Multi-cycle unit stand-in: done after a fixed or random delay.
    initial begin
        mc_done = 1'b0;
        forever begin
            @(negedge clk);
            mc_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mc_done = 1'b1;
            end else if (mc_start === 1'b1 && resp_delay != 0) begin
                cnt = (resp_delay < 0) ? int'($urandom_range(1, 20)) : resp_delay;
            end else if (resp_delay < 0 && $urandom_range(0, 19) == 0) begin
                mc_done = 1'b1;
            end
        end
    end

    task automatic pulse_go;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic step(input int exp_pc);
        pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        check("step idle", busy, 0);
        check("step pc", pc, exp_pc);
    endtask

    initial begin
        int         we_cnt;
        logic [2:0] c_wa, c_ra0, c_ra1;
        logic       c_sub;
        rst = 0; go = 0; run_mode = 0; prog_mode = 0;
        for (int i = 0; i < 8; i++) mem[i] = 12'hE00;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        check("rst pc", pc, 0);
        check("rst busy", busy, 0);
        check("rst halted", halted, 0);
        check("rst err", err, 0);
        check("rst rf_we", rf_we, 0);
        check("rst mc_start", mc_start, 0);
        check("rst imem_addr", imem_addr, 0);
        rst = 0;

        // ADD r3 = r0 + r1 then HALT, free run
        mem[0] = 12'h6C1;
        mem[1] = 12'hE00;
        run_mode = 1;
        pulse_go();
        we_cnt = 0; c_wa = 0; c_ra0 = 0; c_ra1 = 0; c_sub = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                we_cnt++;
                c_wa = rf_wa; c_ra0 = rf_ra0; c_ra1 = rf_ra1; c_sub = alu_sub;
            end
        end
        check("add we pulses", we_cnt, 1);
        check("add wa", c_wa, 3);
        check("add ra0", c_ra0, 0);
        check("add ra1", c_ra1, 1);
        check("add sub", c_sub, 0);
        check("add halted", halted, 1);
        check("add pc", pc, 1);

        // LOAD r1 <- dm[2], single step
        mem[0] = 12'h012;
        run_mode = 0;
        pulse_go();
        repeat (2) @(negedge clk);
        check("load we", rf_we, 1);
        check("load wb", wb_sel, 1);
        check("load wa", rf_wa, 1);
        check("load dm", dm_addr, 2);
        @(negedge clk);
        check("load pc", pc, 1);
        @(negedge clk);
        check("load idle", busy, 0);

        // ASC sort, done 5 cycles after start
        mem[1] = 12'h904;
        resp_delay = 5;
        pulse_go();
        repeat (2) @(negedge clk);
        check("sort start", mc_start, 1);
        check("sort op", mc_op, 0);
        check("sort arg", mc_arg, 12'h104);
        @(negedge clk);
        check("sort start width", mc_start, 0);
        repeat (4) @(negedge clk);
        check("sort pc held", pc, 1);
        @(negedge clk);
        check("sort pc adv", pc, 2);
        @(negedge clk);

        // DISPLAY with no done: watchdog halt
        mem[2] = 12'hC07;
        resp_delay = 0;
        pulse_go();
        repeat (17) @(negedge clk);
        check("wd not yet", halted, 0);
        @(negedge clk);
        check("wd halted", halted, 1);
        check("wd err", err, 1);
        check("wd pc", pc, 2);
        pulse_go();
        check("restart pc", pc, 0);
        check("restart err", err, 0);
        repeat (4) @(negedge clk);

        // single step through single-cycle ops, wrapping 7 -> 0
        for (int i = 0; i < 8; i++) mem[i] = {3'($urandom_range(0, 3)), 9'($urandom)};
        for (int k = 1; k <= 7; k++) step((1 + k) % 8);

        // go ignored while programming
        prog_mode = 1;
        pulse_go();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prog idle", busy, 0);
        end
        check("prog pc", pc, 0);
        prog_mode = 0;

        // reset during WAIT clears outputs immediately
        mem[0] = 12'hAF1;
        pulse_go();
        repeat (4) @(negedge clk);
        check("desc op", mc_op, 1);
        check("desc arg", mc_arg, 12'h0F1);
        #2 rst = 1;
        #1;
        check("rst wait busy", busy, 0);
        check("rst wait op", mc_op, 0);
        check("rst wait arg", mc_arg, 0);
        @(negedge clk);
        rst = 0;

        // randomized traffic
        resp_delay = -1;
        for (int i = 0; i < 8; i++) mem[i] = {3'($urandom_range(0, 6)), 9'($urandom)};
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = 0;
            go = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) run_mode = 1'($urandom);
            if ($urandom_range(0, 15) == 0) prog_mode = 1'($urandom);
            if ((m_ph == P_IDLE || m_ph == P_HALT) && $urandom_range(0, 3) == 0)
                mem[$urandom_range(0, 7)] = ($urandom_range(0, 15) == 0) ?
                    {3'd7, 9'($urandom)} :
                    {3'($urandom_range(0, 6)), 9'($urandom)};
            if ($urandom_range(0, 599) == 0) #2 rst = 1;
        end
        @(negedge clk);
        rst = 0;
        go = 0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
